friet_c_stream_upsizer: RTL and testbench

- Parametrised successor to the single-stage stream input buffer in the Friet-C stream datapath.
- Packs narrow byte-sized beats (din/din_size/din_last) into 128-bit-class blocks and queues them in a DEPTH-entry output FIFO. The permutation core can then absorb back-to-back blocks while the host keeps streaming.
- Sits between the external din bus and the permutation-core din port.

---
 rtl/friet_c_stream_pkg.sv | 27 ++
 rtl/friet_c_stream_upsizer_fifo.sv | 72 +++++++
 rtl/friet_c_stream_upsizer.sv | 110 +++++++++++
 tb/tb_friet_c_stream_upsizer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/friet_c_stream_pkg.sv
// Friet-C stream datapath shared definitions.
// Holds the derived constants for the default configuration, the message pad byte,
// and helpers that size the FIFO pointers and the FIFO entry {last, size, data}.
// Modules with non-default parameters derive their own constants with the helpers.
package friet_c_stream_pkg;

    localparam logic [7:0] PAD_BYTE = 8'h01;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

    // A one-entry FIFO still needs a one-bit pointer to hold the constant zero.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // FIFO entry layout, MSB first: {last, size[size_w:0], data[data_w-1:0]}.
    function automatic int entry_width(input int data_w, input int size_w);
        return 1 + (size_w + 1) + data_w;
    endfunction

    localparam int DIN_BYTES  = bytes_of(32);
    localparam int DOUT_BYTES = bytes_of(128);
    localparam int PTR_WIDTH  = ptr_width(2);

endpackage

// File: rtl/friet_c_stream_upsizer_fifo.sv
// Generic synchronous FIFO with registered occupancy.
// Ports: clk/rst (sync, active-high); push/wdata write the tail; pop releases the head;
// rdata shows the head entry; empty, level, full (registered) and next_full (the value
// full takes after the coming edge). Pushes while full and pops while empty are ignored.
module friet_c_stream_upsizer_fifo
    import friet_c_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 pop,
    output logic [WIDTH-1:0]     rdata,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] level,
    output logic                 full,
    output logic                 next_full
);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] level_q, level_d;
    logic                 full_q;
    logic                 do_push, do_pop;

    // Wrap explicitly so DEPTH=1 keeps the pointer pinned at zero.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push  = push & ~full_q;
        do_pop   = pop & (level_q != '0);
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q + CNT_WIDTH'(do_push) - CNT_WIDTH'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= next_full;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign next_full = (level_d == CNT_WIDTH'(DEPTH));
    assign rdata     = mem_q[rd_ptr_q];
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign full      = full_q;

endmodule

// File: rtl/friet_c_stream_upsizer.sv
// Friet-C stream upsizer: packs narrow din beats into DOUT_WIDTH blocks and queues them
// in a DEPTH-entry FIFO ahead of the permutation core.
// Ports: clk/rst (sync, active-high); din/din_size/din_last/din_valid/din_ready input
// stream (din_size bytes taken from the low end); dout/dout_size/dout_last/dout_valid/
// dout_ready block stream from the FIFO head; level, fifo_full, next_fifo_full status.
// Optional: define FRIET_C_STREAM_UPSIZER_PAD_EN to write pad byte 0x01 just after the
// data of a short last block (dout_size still counts data bytes only).
module friet_c_stream_upsizer
    import friet_c_stream_pkg::*;
#(
    parameter int DIN_WIDTH       = 32,
    parameter int DIN_SIZE_WIDTH  = 2,
    parameter int DOUT_WIDTH      = 128,
    parameter int DOUT_SIZE_WIDTH = 4,
    parameter int DEPTH           = 2,
    parameter int CNT_WIDTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIN_WIDTH-1:0]       din,
    input  logic [DIN_SIZE_WIDTH:0]    din_size,
    input  logic                       din_last,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [DOUT_WIDTH-1:0]      dout,
    output logic [DOUT_SIZE_WIDTH:0]   dout_size,
    output logic                       dout_last,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [CNT_WIDTH-1:0]       level,
    output logic                       fifo_full,
    output logic                       next_fifo_full
);
    localparam int DIN_B   = bytes_of(DIN_WIDTH);
    localparam int DOUT_B  = bytes_of(DOUT_WIDTH);
    localparam int FILL_W  = DOUT_SIZE_WIDTH + 1;
    localparam int ENTRY_W = entry_width(DOUT_WIDTH, DOUT_SIZE_WIDTH);

    logic [FILL_W-1:0]     fill_q, fill_d, fill_new;
    logic [DOUT_WIDTH-1:0] data_q, data_d, data_new, block;
    logic [DIN_WIDTH-1:0]  din_masked;
    logic                  accept, blk_close, fifo_empty;
    logic [ENTRY_W-1:0]    wr_entry, rd_entry;

    assign din_ready = ~fifo_full;
    assign accept    = din_valid & din_ready;

    always_comb begin
        // Bytes above din_size are dropped so the unused accumulator bytes stay zero.
        din_masked = '0;
        for (int i = 0; i < DIN_B; i++) begin
            if (i < int'(din_size)) begin
                din_masked[8*i +: 8] = din[8*i +: 8];
            end
        end

        fill_new  = fill_q + FILL_W'(din_size);
        data_new  = data_q | (DOUT_WIDTH'(din_masked) << {fill_q, 3'b000});
        blk_close = accept & (din_last | (fill_new == FILL_W'(DOUT_B)));

        block = data_new;
`ifdef FRIET_C_STREAM_UPSIZER_PAD_EN
        if (din_last && (fill_new < FILL_W'(DOUT_B))) begin
            block = data_new | (DOUT_WIDTH'(PAD_BYTE) << {fill_new, 3'b000});
        end
`endif

        fill_d = fill_q;
        data_d = data_q;
        if (accept) begin
            fill_d = blk_close ? '0 : fill_new;
            data_d = blk_close ? '0 : data_new;
        end

        wr_entry = {din_last, fill_new, block};
    end

    // Accumulator data is cleared on reset so a restarted message carries no residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
            data_q <= '0;
        end else begin
            fill_q <= fill_d;
            data_q <= data_d;
        end
    end

    friet_c_stream_upsizer_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (blk_close),
        .wdata     (wr_entry),
        .pop       (dout_ready),
        .rdata     (rd_entry),
        .empty     (fifo_empty),
        .level     (level),
        .full      (fifo_full),
        .next_full (next_fifo_full)
    );

    // Head fields read as zero while the FIFO is empty.
    assign dout_valid = ~fifo_empty;
    assign {dout_last, dout_size, dout} = dout_valid ? rd_entry : '0;

endmodule

// File: tb/tb_friet_c_stream_upsizer.sv
`timescale 1ns/1ps
module tb_friet_c_stream_upsizer;
    localparam int DIN_B  = 4;
    localparam int DOUT_B = 16;
`ifdef FRIET_C_STREAM_UPSIZER_PAD_EN
    localparam logic [7:0] EXP_PAD = 8'h01;
`else
    localparam logic [7:0] EXP_PAD = 8'h00;
`endif
    localparam logic [127:0] SEQ_BLOCK = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

    typedef struct packed {
        logic         last;
        logic [4:0]   size;
        logic [127:0] data;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  din = '0;
    logic [2:0]   din_size = '0;
    logic         din_last = 1'b0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [127:0] dout;
    logic [4:0]   dout_size;
    logic         dout_last;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic [1:0]   level;
    logic         fifo_full;
    logic         next_fifo_full;

    int checks = 0;
    int errors = 0;

    byte unsigned cur[$];
    blk_t model_q[$], obs_q[$], exp_q[$];
    blk_t nb;

    friet_c_stream_upsizer dut (
        .clk(clk), .rst(rst), .din(din), .din_size(din_size), .din_last(din_last),
        .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .dout_size(dout_size),
        .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level), .fifo_full(fifo_full), .next_fifo_full(next_fifo_full)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the current message collect in a queue; a block is
    // formed when 16 bytes are held or the message ends. Events are taken at the
    // negative edge for the rising edge that follows.
    always @(negedge clk) begin
        if (rst) begin
            cur.delete();
            model_q.delete();
        end else begin
            if (dout_valid && dout_ready) begin
                obs_q.push_back({dout_last, dout_size, dout});
                if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
                else exp_q.push_back({1'b1, 5'h1f, {128{1'b1}}});
            end
            if (din_valid && din_ready) begin
                for (int i = 0; i < int'(din_size); i++) cur.push_back(din[8*i +: 8]);
                if (cur.size() >= DOUT_B || din_last) begin
                    nb = '0;
                    nb.last = din_last;
                    nb.size = 5'(cur.size());
                    for (int i = 0; i < cur.size(); i++) nb.data[8*i +: 8] = cur[i];
                    if (din_last && cur.size() < DOUT_B) nb.data[8*cur.size() +: 8] = EXP_PAD;
                    model_q.push_back(nb);
                    cur.delete();
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] d, input int sz, input bit last);
        int n;
        if (!last && sz != DIN_B) begin
            errors++;
            $display("FAIL protocol partial non-last beat size %0d required %0d", sz, DIN_B);
        end
        din = d; din_size = 3'(sz); din_last = last; din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout din_ready=%0b required 1", din_ready);
        end
        @(posedge clk); #1;
        din_valid = 1'b0; din_last = 1'b0; din_size = '0; din = $urandom;
    endtask

    task automatic send_msg(input int len, input bit extra_empty);
        int rem;
        rem = len;
        while (rem > DIN_B) begin
            send($urandom, DIN_B, 1'b0);
            rem -= DIN_B;
        end
        if (rem == DIN_B && extra_empty) begin
            send($urandom, DIN_B, 1'b0);
            send($urandom, 0, 1'b1);
        end else begin
            send($urandom, rem, 1'b1);
        end
    endtask

    task automatic drain();
        dout_ready = 1'b1;
        for (int i = 0; i < 20 && dout_valid; i++) begin
            @(posedge clk); #1;
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %0b exp 0", dout_valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
        checks++; if (dout_size !== '0) begin errors++; $display("FAIL reset_dout_size got %0d exp 0", dout_size); end
        checks++; if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_dout_last got %0b exp 0", dout_last); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got %0b exp 0", fifo_full); end
        checks++; if (next_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_next_fifo_full got %0b exp 0", next_fifo_full); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %0b exp 1", din_ready); end
    endtask

    task automatic test_full_block();
        dout_ready = 1'b0;
        send(32'h03020100, 4, 1'b0);
        send(32'h07060504, 4, 1'b0);
        send(32'h0B0A0908, 4, 1'b0);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %0b exp 0", dout_valid); end
        send(32'h0F0E0D0C, 4, 1'b1);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %0b exp 1", dout_valid); end
        checks++; if (dout !== SEQ_BLOCK) begin errors++; $display("FAIL full_dout got %h exp %h", dout, SEQ_BLOCK); end
        checks++; if (dout_size !== 5'd16) begin errors++; $display("FAIL full_size got %0d exp 16", dout_size); end
        checks++; if (dout_last !== 1'b1) begin errors++; $display("FAIL full_last got %0b exp 1", dout_last); end
        checks++; if (level !== 2'd1) begin errors++; $display("FAIL full_level got %0d exp 1", level); end
        dout_ready = 1'b1;
        @(posedge clk); #1 dout_ready = 1'b0;
        checks++; if (dout_valid !== 1'b0 || dout !== '0) begin errors++; $display("FAIL full_popped valid=%0b dout=%h exp 0 0", dout_valid, dout); end
    endtask

    task automatic test_partial();
        dout_ready = 1'b0;
        repeat (5) send($urandom, 4, 1'b0);
        send($urandom, 2, 1'b1);
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL partial_level got %0d exp 2", level); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL partial_fifo_full got %0b exp 1", fifo_full); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL partial_din_ready got %0b exp 0", din_ready); end
        checks++; if (dout_size !== 5'd16 || dout_last !== 1'b0) begin errors++; $display("FAIL partial_blk1 size=%0d last=%0b exp 16 0", dout_size, dout_last); end
        dout_ready = 1'b1;
        #1;
        checks++; if (next_fifo_full !== 1'b0) begin errors++; $display("FAIL pop_next_full got %0b exp 0", next_fifo_full); end
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL pop_same_cycle_ready got %0b exp 0", din_ready); end
        @(posedge clk); #1 dout_ready = 1'b0;
        checks++; if (level !== 2'd1 || fifo_full !== 1'b0) begin errors++; $display("FAIL pop_level level=%0d full=%0b exp 1 0", level, fifo_full); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL pop_next_cycle_ready got %0b exp 1", din_ready); end
        checks++; if (dout_size !== 5'd6 || dout_last !== 1'b1) begin errors++; $display("FAIL partial_blk2 size=%0d last=%0b exp 6 1", dout_size, dout_last); end
        checks++; if (dout[127:56] !== '0) begin errors++; $display("FAIL partial_upper got %h exp 0", dout[127:56]); end
        checks++; if (dout[55:48] !== EXP_PAD) begin errors++; $display("FAIL partial_pad got %h exp %h", dout[55:48], EXP_PAD); end
        drain();
    endtask

    task automatic test_simul_push_pop();
        dout_ready = 1'b0;
        send($urandom, 4, 1'b1);
        din = $urandom; din_size = 3'd4; din_last = 1'b1; din_valid = 1'b1;
        #1;
        checks++; if (next_fifo_full !== 1'b1) begin errors++; $display("FAIL push_next_full got %0b exp 1", next_fifo_full); end
        dout_ready = 1'b1;
        #1;
        checks++; if (next_fifo_full !== 1'b0) begin errors++; $display("FAIL pushpop_next_full got %0b exp 0", next_fifo_full); end
        @(posedge clk); #1;
        din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
        checks++; if (level !== 2'd1 || dout_valid !== 1'b1) begin errors++; $display("FAIL pushpop_level level=%0d valid=%0b exp 1 1", level, dout_valid); end
        drain();
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL pushpop_drain level=%0d exp 0", level); end
    endtask

    task automatic test_empty_last();
        dout_ready = 1'b0;
        send($urandom, 0, 1'b1);
        checks++; if (dout_valid !== 1'b1 || dout_size !== 5'd0 || dout_last !== 1'b1) begin errors++; $display("FAIL empty_blk valid=%0b size=%0d last=%0b exp 1 0 1", dout_valid, dout_size, dout_last); end
        checks++; if (dout !== {120'd0, EXP_PAD}) begin errors++; $display("FAIL empty_dout got %h exp %h", dout, {120'd0, EXP_PAD}); end
        send($urandom, 4, 1'b0);
        send($urandom, 0, 1'b1);
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL close_partial_level got %0d exp 2", level); end
        dout_ready = 1'b1;
        @(posedge clk); #1 dout_ready = 1'b0;
        checks++; if (dout_size !== 5'd4 || dout_last !== 1'b1 || dout[39:32] !== EXP_PAD) begin errors++; $display("FAIL close_partial size=%0d last=%0b pad=%h exp 4 1 %h", dout_size, dout_last, dout[39:32], EXP_PAD); end
        drain();
    endtask

    task automatic test_back_to_back();
        dout_ready = 1'b0;
        fork
            repeat (3) send_msg(16, 1'b0);
            begin
                repeat (30) @(posedge clk);
                #1;
                checks++; if (level !== 2'd2 || fifo_full !== 1'b1) begin errors++; $display("FAIL bp_level level=%0d full=%0b exp 2 1", level, fifo_full); end
                checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_din_ready got %0b exp 0", din_ready); end
                dout_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b0;
        send_msg(16, 1'b0);
        send($urandom, 4, 1'b0);
        send($urandom, 4, 1'b0);
        din = $urandom; din_size = 3'd4; din_last = 1'b0; din_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; din_valid = 1'b0;
        checks++; if (dout_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL midrst valid=%0b level=%0d exp 0 0", dout_valid, level); end
        send(32'h03020100, 4, 1'b0);
        send(32'h07060504, 4, 1'b0);
        send(32'h0B0A0908, 4, 1'b0);
        send(32'h0F0E0D0C, 4, 1'b1);
        checks++; if (level !== 2'd1 || dout !== SEQ_BLOCK || dout_size !== 5'd16) begin errors++; $display("FAIL midrst_block level=%0d dout=%h size=%0d exp 1 %h 16", level, dout, dout_size, SEQ_BLOCK); end
        drain();
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int m = 0; m < 25; m++) send_msg($urandom_range(0, 40), 1'($urandom_range(0, 1)));
                done = 1'b1;
            end
            while (!done) begin
                dout_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        join
        drain();
    endtask

    task automatic test_scoreboard();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sb_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sb_block %0d got last=%0b size=%0d data=%h exp last=%0b size=%0d data=%h",
                         i, obs_q[i].last, obs_q[i].size, obs_q[i].data, exp_q[i].last, exp_q[i].size, exp_q[i].data);
            end
        end
        checks++; if (model_q.size() != 0 || dout_valid !== 1'b0) begin errors++; $display("FAIL sb_leftover model=%0d valid=%0b exp 0 0", model_q.size(), dout_valid); end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_partial();
        test_simul_push_pop();
        test_empty_last();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_scoreboard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
